// File: rtl/riscv_mem_pkg.sv
// Shared constants, types and helpers for the MEM-stage load/store unit.
package riscv_mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } bus_req_t;

    // Any funct3 outside the defined load/store widths is handled as a word access.
    function automatic logic [2:0] norm_f3(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: return f3;
            default:                        return F3_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return off[0];
            default:     return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/replication and load extraction/extension.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic [XLEN-1:0] ld_word_i,
    output logic [BE_W-1:0] be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] ld_data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be_c      = 4'b1111;
        wdata_c   = st_data_i;
        ld_data_c = ld_word_i;

        case (off_i)
            2'd0:    byte_v = ld_word_i[7:0];
            2'd1:    byte_v = ld_word_i[15:8];
            2'd2:    byte_v = ld_word_i[23:16];
            default: byte_v = ld_word_i[31:24];
        endcase
        half_v = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

        case (funct3_i)
            F3_B, F3_BU: begin
                be_c    = 4'b0001 << off_i;
                wdata_c = {4{st_data_i[7:0]}};
            end
            F3_H, F3_HU: begin
                be_c    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase

        case (funct3_i)
            F3_B:    ld_data_c = {{24{byte_v[7]}}, byte_v};
            F3_BU:   ld_data_c = {24'd0, byte_v};
            F3_H:    ld_data_c = {{16{half_v[15]}}, half_v};
            F3_HU:   ld_data_c = {16'd0, half_v};
            default: ld_data_c = ld_word_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus access per memory instruction, stalling the
// pipeline while it is outstanding, with an optional no-ack timeout.
module mem_lsu
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            mem_rd_i,
    input  logic            mem_wr_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [XLEN-1:0] ld_data_o,
    output logic            stall_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [BE_W-1:0] bus_be_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_ack_i,
    input  logic [XLEN-1:0] bus_rdata_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bus_req_t        bus_q, bus_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] ld_data_q, ld_data_d;
    logic            misalign_q, misalign_d;
    logic            err_q, err_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic            is_ld_q, is_ld_d;

    logic [2:0]      f3_n;
    logic [2:0]      al_f3;
    logic [1:0]      al_off;
    logic [BE_W-1:0] be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] ld_ext_c;

    assign f3_n   = norm_f3(funct3_i);
    // Steering follows the live inputs when issuing, the latched access once in flight.
    assign al_f3  = (state_q == IDLE) ? f3_n : f3_q;
    assign al_off = (state_q == IDLE) ? addr_i[1:0] : off_q;

    lsu_align u_align (
        .funct3_i  (al_f3),
        .off_i     (al_off),
        .st_data_i (st_data_i),
        .ld_word_i (bus_rdata_i),
        .be_c      (be_c),
        .wdata_c   (wdata_c),
        .ld_data_c (ld_ext_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus_d      = bus_q;
        req_d      = req_q;
        ld_data_d  = ld_data_q;
        misalign_d = 1'b0;
        err_d      = 1'b0;
        f3_d       = f3_q;
        off_d      = off_q;
        is_ld_d    = is_ld_q;
        stall_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_rd_i || mem_wr_i) begin
                    if (is_misaligned(f3_n, addr_i[1:0])) begin
                        misalign_d = 1'b1;
                        ld_data_d  = '0;
                    end else begin
                        stall_o     = 1'b1;
                        req_d       = 1'b1;
                        bus_d.we    = mem_wr_i;
                        bus_d.addr  = {addr_i[XLEN-1:2], 2'b00};
                        bus_d.be    = be_c;
                        bus_d.wdata = wdata_c;
                        f3_d        = f3_n;
                        off_d       = addr_i[1:0];
                        is_ld_d     = mem_rd_i;
                        cnt_d       = '0;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (bus_ack_i) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                    if (is_ld_q) begin
                        ld_data_d = ld_ext_c;
                    end
                end else if (TO_EN && (cnt_q == CNT_MAX)) begin
                    req_d     = 1'b0;
                    err_d     = 1'b1;
                    ld_data_d = '0;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bus_q      <= '0;
            req_q      <= 1'b0;
            ld_data_q  <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            is_ld_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bus_q      <= bus_d;
            req_q      <= req_d;
            ld_data_q  <= ld_data_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            is_ld_q    <= is_ld_d;
        end
    end

    assign ld_data_o   = ld_data_q;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = err_q;
    assign bus_req_o   = req_q;
    assign bus_we_o    = bus_q.we;
    assign bus_addr_o  = bus_q.addr;
    assign bus_be_o    = bus_q.be;
    assign bus_wdata_o = bus_q.wdata;

endmodule
